// File: rtl/hazard_stall_ctl.sv
// hazard_stall_ctl: central stall/flush sequencer for the 5-stage MIPS pipeline.
// It detects load-use hazards in ID, holds fetch while a branch or jump
// resolves at EX/MEM, and freezes the front of the pipe while a multi-cycle
// MUL occupies EX. It also keeps a saturating count of PC-hold cycles.
module hazard_stall_ctl #(
    parameter int CTRL_LAT   = 2,
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ifid_opcode,
    input  logic [5:0]  ifid_funct,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        exmem_redirect,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_bubble,
    output logic        idex_en,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        mul_start,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CTRL_WAIT = 2'd1,
        MUL_WAIT  = 2'd2
    } state_t;

    // Wait-counter reload values; the counter runs down to zero and the
    // zero cycle is the release cycle, so a wait of N cycles loads N-1.
    localparam logic [CNT_W-1:0] CTRL_INIT = CNT_W'(CTRL_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_INIT  = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            r_state;
    state_t            w_stateNext;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cntNext;
    logic [31:0]       r_stallCnt;

    logic w_isBr;
    logic w_isJ;
    logic w_isMul;
    logic w_usesRt;
    logic w_loadUse;

    logic w_pcEn;
    logic w_ifidEn;
    logic w_ifidBubble;
    logic w_idexEn;
    logic w_idexBubble;
    logic w_exmemBubble;
    logic w_mulStart;

    // Instruction classes decoded from the word sitting in IF/ID.
    assign w_isBr    = (ifid_opcode == 6'd4) || (ifid_opcode == 6'd5);
    assign w_isJ     = (ifid_opcode == 6'd2);
    assign w_isMul   = (ifid_opcode == 6'd0) && (ifid_funct == 6'd25);
    assign w_usesRt  = (ifid_opcode == 6'd0) || (ifid_opcode == 6'd4) ||
                       (ifid_opcode == 6'd5) || (ifid_opcode == 6'd43);

    // A load in EX whose destination feeds a source of the instruction in ID;
    // $zero never creates a dependency.
    assign w_loadUse = idex_memread && (idex_rt != 5'd0) &&
                       ((idex_rt == ifid_rs) || (w_usesRt && (idex_rt == ifid_rt)));

    // State register and wait counter; reset abandons any wait in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state and enable/bubble generation; default is a free-running pipe.
    always_comb begin
        w_pcEn        = 1'b1;
        w_ifidEn      = 1'b1;
        w_ifidBubble  = 1'b0;
        w_idexEn      = 1'b1;
        w_idexBubble  = 1'b0;
        w_exmemBubble = 1'b0;
        w_mulStart    = 1'b0;
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;

        case (r_state)
            RUN: begin
                if (w_loadUse) begin
                    w_pcEn       = 1'b0;
                    w_ifidEn     = 1'b0;
                    w_idexBubble = 1'b1;
                end else if (w_isBr || w_isJ) begin
                    w_pcEn       = 1'b0;
                    w_ifidBubble = 1'b1;
                    w_stateNext  = CTRL_WAIT;
                    w_cntNext    = CTRL_INIT;
                end else if (w_isMul) begin
                    w_stateNext  = MUL_WAIT;
                    w_cntNext    = MUL_INIT;
                end
            end

            CTRL_WAIT: begin
                if (r_cnt != '0) begin
                    w_pcEn       = 1'b0;
                    w_ifidBubble = 1'b1;
                    w_cntNext    = r_cnt - CNT_ONE;
                end else begin
                    // Branch is in EX/MEM: taken/jump loads the target and
                    // squashes IF/ID; not-taken lets branch+4 enter IF/ID.
                    w_pcEn       = exmem_redirect;
                    w_ifidBubble = exmem_redirect;
                    w_stateNext  = RUN;
                end
            end

            MUL_WAIT: begin
                w_mulStart = (r_cnt == MUL_INIT);
                if (r_cnt != '0) begin
                    w_pcEn        = 1'b0;
                    w_ifidEn      = 1'b0;
                    w_idexEn      = 1'b0;
                    w_exmemBubble = 1'b1;
                    w_cntNext     = r_cnt - CNT_ONE;
                end else begin
                    w_stateNext = RUN;
                end
            end

            default: begin
                w_stateNext = RUN;
                w_cntNext   = '0;
            end
        endcase
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallCnt <= '0;
        end else if (!w_pcEn && (r_stallCnt != 32'hFFFF_FFFF)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    // While reset is low the pipe is frozen and every stage is bubbled.
    assign pc_en        = rst & w_pcEn;
    assign ifid_en      = rst & w_ifidEn;
    assign idex_en      = rst & w_idexEn;
    assign ifid_bubble  = ~rst | w_ifidBubble;
    assign idex_bubble  = ~rst | w_idexBubble;
    assign exmem_bubble = ~rst | w_exmemBubble;
    assign mul_start    = rst & w_mulStart;
    assign state_o      = r_state;
    assign stall_cnt    = r_stallCnt;

endmodule

// File: tb/tb_hazard_stall_ctl.sv
// tb_hazard_stall_ctl: directed bench for the pipeline stall/flush sequencer
// with default parameters (CTRL_LAT=2, MUL_CYCLES=32).
module tb_hazard_stall_ctl;

    logic        clk;
    logic        rst;
    logic [5:0]  ifidOpcode;
    logic [5:0]  ifidFunct;
    logic [4:0]  ifidRs;
    logic [4:0]  ifidRt;
    logic        idexMemread;
    logic [4:0]  idexRt;
    logic        exmemRedirect;
    logic        pcEn;
    logic        ifidEn;
    logic        ifidBubble;
    logic        idexEn;
    logic        idexBubble;
    logic        exmemBubble;
    logic        mulStart;
    logic [1:0]  stateO;
    logic [31:0] stallCnt;

    int checks;
    int errors;
    int expStall;

    hazard_stall_ctl dut (
        .clk            (clk),
        .rst            (rst),
        .ifid_opcode    (ifidOpcode),
        .ifid_funct     (ifidFunct),
        .ifid_rs        (ifidRs),
        .ifid_rt        (ifidRt),
        .idex_memread   (idexMemread),
        .idex_rt        (idexRt),
        .exmem_redirect (exmemRedirect),
        .pc_en          (pcEn),
        .ifid_en        (ifidEn),
        .ifid_bubble    (ifidBubble),
        .idex_en        (idexEn),
        .idex_bubble    (idexBubble),
        .exmem_bubble   (exmemBubble),
        .mul_start      (mulStart),
        .state_o        (stateO),
        .stall_cnt      (stallCnt)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs on the falling edge, then let outputs settle.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic memRead, input logic [4:0] exRt,
                                 input logic redirect);
        @(negedge clk);
        ifidOpcode    = op;
        ifidFunct     = funct;
        ifidRs        = rs;
        ifidRt        = rt;
        idexMemread   = memRead;
        idexRt        = exRt;
        exmemRedirect = redirect;
        #1;
    endtask

    // One comparison of an observed value against a hand-computed one.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // All seven control outputs compared against an expected pattern.
    task automatic checkCtl(input string tag, input logic ePc, input logic eIfidEn,
                            input logic eIfidBub, input logic eIdexEn,
                            input logic eIdexBub, input logic eExmemBub,
                            input logic eMulStart, input logic [1:0] eState);
        checkOutput({tag, ".pc_en"},        {31'd0, pcEn},        {31'd0, ePc});
        checkOutput({tag, ".ifid_en"},      {31'd0, ifidEn},      {31'd0, eIfidEn});
        checkOutput({tag, ".ifid_bubble"},  {31'd0, ifidBubble},  {31'd0, eIfidBub});
        checkOutput({tag, ".idex_en"},      {31'd0, idexEn},      {31'd0, eIdexEn});
        checkOutput({tag, ".idex_bubble"},  {31'd0, idexBubble},  {31'd0, eIdexBub});
        checkOutput({tag, ".exmem_bubble"}, {31'd0, exmemBubble}, {31'd0, eExmemBub});
        checkOutput({tag, ".mul_start"},    {31'd0, mulStart},    {31'd0, eMulStart});
        checkOutput({tag, ".state"},        {30'd0, stateO},      {30'd0, eState});
    endtask

    // Directed sequence covering reset, load-use, branches, jump, MUL and
    // asynchronous reset in the middle of a MUL wait.
    initial begin
        checks        = 0;
        errors        = 0;
        expStall      = 0;
        rst           = 1'b0;
        ifidOpcode    = 6'd0;
        ifidFunct     = 6'd25;
        ifidRs        = 5'd3;
        ifidRt        = 5'd4;
        idexMemread   = 1'b0;
        idexRt        = 5'd0;
        exmemRedirect = 1'b0;

        $display("[TB] reset held with MUL in ID");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(6'd0, 6'd25, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
            checkCtl("reset", 0, 0, 1, 0, 1, 1, 0, 2'd0);
            checkOutput("reset.stall_cnt", stallCnt, 32'd0);
        end

        $display("[TB] release reset");
        @(negedge clk);
        rst        = 1'b1;
        ifidFunct  = 6'd0;
        ifidRs     = 5'd0;
        ifidRt     = 5'd0;
        #1;
        checkCtl("release", 1, 1, 0, 1, 0, 0, 0, 2'd0);
        checkOutput("release.stall_cnt", stallCnt, 32'd0);

        $display("[TB] load-use on rt");
        applyStimulus(6'd0, 6'd32, 5'd1, 5'd8, 1'b1, 5'd8, 1'b0);
        checkCtl("lu_rt", 0, 0, 0, 1, 1, 0, 0, 2'd0);
        expStall++;
        applyStimulus(6'd0, 6'd32, 5'd1, 5'd8, 1'b0, 5'd0, 1'b0);
        checkCtl("lu_rt_after", 1, 1, 0, 1, 0, 0, 0, 2'd0);
        checkOutput("lu_rt.stall_cnt", stallCnt, 32'(expStall));

        $display("[TB] load to $zero never stalls");
        applyStimulus(6'd0, 6'd32, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        checkCtl("lu_zero", 1, 1, 0, 1, 0, 0, 0, 2'd0);

        $display("[TB] load-use on rs with a lw in ID");
        applyStimulus(6'd35, 6'd0, 5'd9, 5'd2, 1'b1, 5'd9, 1'b0);
        checkCtl("lu_rs", 0, 0, 0, 1, 1, 0, 0, 2'd0);
        expStall++;

        $display("[TB] rt match ignored when ID does not read rt");
        applyStimulus(6'd35, 6'd0, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0);
        checkCtl("lu_rt_unused", 1, 1, 0, 1, 0, 0, 0, 2'd0);
        checkOutput("lu_rs.stall_cnt", stallCnt, 32'(expStall));

        $display("[TB] taken beq");
        applyStimulus(6'd4, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        checkCtl("beq_id", 0, 1, 1, 1, 0, 0, 0, 2'd0);
        expStall++;
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("beq_wait", 0, 1, 1, 1, 0, 0, 0, 2'd1);
        expStall++;
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        checkCtl("beq_release", 1, 1, 1, 1, 0, 0, 0, 2'd1);
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("beq_after", 1, 1, 0, 1, 0, 0, 0, 2'd0);
        checkOutput("beq.stall_cnt", stallCnt, 32'(expStall));

        $display("[TB] redirect ignored while running");
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        checkCtl("redirect_run", 1, 1, 0, 1, 0, 0, 0, 2'd0);

        $display("[TB] not-taken bne");
        applyStimulus(6'd5, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        checkCtl("bne_id", 0, 1, 1, 1, 0, 0, 0, 2'd0);
        expStall++;
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("bne_wait", 0, 1, 1, 1, 0, 0, 0, 2'd1);
        expStall++;
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("bne_release", 0, 1, 0, 1, 0, 0, 0, 2'd1);
        expStall++;
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("bne_after", 1, 1, 0, 1, 0, 0, 0, 2'd0);
        checkOutput("bne.stall_cnt", stallCnt, 32'(expStall));

        $display("[TB] jump");
        applyStimulus(6'd2, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("j_id", 0, 1, 1, 1, 0, 0, 0, 2'd0);
        expStall++;
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("j_wait", 0, 1, 1, 1, 0, 0, 0, 2'd1);
        expStall++;
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        checkCtl("j_release", 1, 1, 1, 1, 0, 0, 0, 2'd1);

        $display("[TB] MUL occupancy");
        applyStimulus(6'd0, 6'd25, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
        checkCtl("mul_id", 1, 1, 0, 1, 0, 0, 0, 2'd0);
        for (int i = 0; i < 31; i++) begin
            applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
            checkCtl("mul_wait", 0, 0, 0, 0, 0, 1, (i == 0), 2'd2);
            expStall++;
        end
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("mul_release", 1, 1, 0, 1, 0, 0, 0, 2'd2);
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("mul_after", 1, 1, 0, 1, 0, 0, 0, 2'd0);
        checkOutput("mul.stall_cnt", stallCnt, 32'(expStall));

        $display("[TB] asynchronous reset in the middle of a MUL wait");
        applyStimulus(6'd0, 6'd25, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
        checkCtl("mul2_id", 1, 1, 0, 1, 0, 0, 0, 2'd0);
        for (int i = 0; i < 22; i++) begin
            applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        end
        checkCtl("mul2_cnt10", 0, 0, 0, 0, 0, 1, 0, 2'd2);
        #2;
        rst = 1'b0;
        #1;
        checkCtl("async_reset", 0, 0, 1, 0, 1, 1, 0, 2'd0);
        checkOutput("async_reset.stall_cnt", stallCnt, 32'd0);
        applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkCtl("async_hold", 0, 0, 1, 0, 1, 1, 0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkCtl("post_reset", 1, 1, 0, 1, 0, 0, 0, 2'd0);
            checkOutput("post_reset.stall_cnt", stallCnt, 32'd0);
            applyStimulus(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
